// File: rtl/imm_ext_pkg.sv
// Shared constants for the immediate-extension stage: mode codes and occupancy states.
package imm_ext_pkg;

  localparam int unsigned MODE_W = 2;

  localparam logic [MODE_W-1:0] MODE_SEXT   = 2'b00;
  localparam logic [MODE_W-1:0] MODE_ZEXT   = 2'b01;
  localparam logic [MODE_W-1:0] MODE_UPPER  = 2'b10;
  localparam logic [MODE_W-1:0] MODE_BRANCH = 2'b11;

  // Occupancy of the out register / skid pair
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_TWO   = 2'b10
  } occ_state_e;

endpackage : imm_ext_pkg

// File: rtl/imm_ext_core.sv
// Combinational immediate extension: (data, mode) -> (extended operand, branch overflow flag).
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = 16,
  parameter int unsigned OUT_WIDTH = 32,
  parameter int unsigned SHIFT_AMT = 2
) (
  input  logic [IN_WIDTH-1:0]  data_i,
  input  logic [MODE_W-1:0]    mode_i,
  output logic [OUT_WIDTH-1:0] ext_c_o,
  output logic                 lost_c_o
);

  localparam int unsigned EXT_W = OUT_WIDTH - IN_WIDTH;

  logic [OUT_WIDTH-1:0] hi_mask_c;
  logic [OUT_WIDTH-1:0] zext_c;
  logic [OUT_WIDTH-1:0] sext_c;
  logic [OUT_WIDTH-1:0] upper_c;
  logic [OUT_WIDTH-1:0] branch_c;
  logic [OUT_WIDTH-1:0] unshift_c;

  // Candidate results for every mode; the high mask collapses to zero when EXT_W == 0
  always_comb begin
    hi_mask_c = ~((OUT_WIDTH'(1) << IN_WIDTH) - OUT_WIDTH'(1));
    zext_c    = OUT_WIDTH'(data_i);
    sext_c    = data_i[IN_WIDTH-1] ? (zext_c | hi_mask_c) : zext_c;
    upper_c   = zext_c << EXT_W;
    branch_c  = sext_c << SHIFT_AMT;
    // Shifting back arithmetically recovers sext only if no significant bit was lost
    unshift_c = $signed(branch_c) >>> SHIFT_AMT;
  end

  // Mode select; overflow flag only meaningful for branch offsets
  always_comb begin
    ext_c_o  = sext_c;
    lost_c_o = 1'b0;
    case (mode_i)
      MODE_SEXT:   ext_c_o = sext_c;
      MODE_ZEXT:   ext_c_o = zext_c;
      MODE_UPPER:  ext_c_o = upper_c;
      MODE_BRANCH: begin
        ext_c_o  = branch_c;
        lost_c_o = (unshift_c != sext_c);
      end
      default: begin
        ext_c_o  = sext_c;
        lost_c_o = 1'b0;
      end
    endcase
  end

endmodule : imm_ext_core

// File: rtl/imm_extend_pipe.sv
// Immediate-extension stage with registered output and a 2-entry skid buffer (valid/ready).
module imm_extend_pipe
  import imm_ext_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = 16,
  parameter int unsigned OUT_WIDTH = 32,
  parameter int unsigned SHIFT_AMT = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic [MODE_W-1:0]    in_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_lost
);

  occ_state_e state_q, state_d;

  logic                 in_ready_q,  in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic [OUT_WIDTH-1:0] out_data_q,  out_data_d;
  logic                 out_lost_q,  out_lost_d;
  logic [OUT_WIDTH-1:0] skid_data_q, skid_data_d;
  logic                 skid_lost_q, skid_lost_d;

  logic [OUT_WIDTH-1:0] ext_c;
  logic                 lost_c;
  logic                 in_fire_c;
  logic                 out_fire_c;

  // Extension happens ahead of the registers so latency stays at one cycle
  imm_ext_core #(
    .IN_WIDTH  (IN_WIDTH),
    .OUT_WIDTH (OUT_WIDTH),
    .SHIFT_AMT (SHIFT_AMT)
  ) u_core (
    .data_i   (in_data),
    .mode_i   (in_mode),
    .ext_c_o  (ext_c),
    .lost_c_o (lost_c)
  );

  assign in_fire_c  = in_valid && in_ready_q;
  assign out_fire_c = out_valid_q && out_ready;

  // Occupancy next-state and datapath steering for out register and skid
  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_lost_d  = out_lost_q;
    skid_data_d = skid_data_q;
    skid_lost_d = skid_lost_q;

    case (state_q)
      ST_EMPTY: begin
        if (in_fire_c) begin
          state_d    = ST_ONE;
          out_data_d = ext_c;
          out_lost_d = lost_c;
        end
      end
      ST_ONE: begin
        if (in_fire_c && out_fire_c) begin
          out_data_d = ext_c;
          out_lost_d = lost_c;
        end else if (in_fire_c) begin
          state_d     = ST_TWO;
          skid_data_d = ext_c;
          skid_lost_d = lost_c;
        end else if (out_fire_c) begin
          state_d    = ST_EMPTY;
          out_data_d = '0;
          out_lost_d = 1'b0;
        end
      end
      ST_TWO: begin
        if (out_fire_c) begin
          state_d    = ST_ONE;
          out_data_d = skid_data_q;
          out_lost_d = skid_lost_q;
        end
      end
      default: begin
        state_d    = ST_EMPTY;
        out_data_d = '0;
        out_lost_d = 1'b0;
      end
    endcase

    out_valid_d = (state_d != ST_EMPTY);
    in_ready_d  = (state_d != ST_TWO);
  end

  // State, handshake flags and data registers; reset discards both entries
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_lost_q  <= 1'b0;
      skid_data_q <= '0;
      skid_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_lost_q  <= out_lost_d;
      skid_data_q <= skid_data_d;
      skid_lost_q <= skid_lost_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_lost  = out_lost_q;

endmodule : imm_extend_pipe

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench for imm_extend_pipe: directed cases plus randomized traffic vs a queue model.
module tb_imm_extend_pipe;
  import imm_ext_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        in_valid, in_ready, out_valid, out_ready, out_lost;
  logic [15:0] in_data;
  logic [1:0]  in_mode;
  logic [31:0] out_data;

  logic        in_valid16, in_ready16, out_valid16, out_ready16, out_lost16;
  logic [15:0] in_data16;
  logic [1:0]  in_mode16;
  logic [15:0] out_data16;

  imm_extend_pipe #(.IN_WIDTH(16), .OUT_WIDTH(32), .SHIFT_AMT(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_lost(out_lost)
  );

  imm_extend_pipe #(.IN_WIDTH(16), .OUT_WIDTH(16), .SHIFT_AMT(2)) dut16 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid16), .in_ready(in_ready16), .in_data(in_data16), .in_mode(in_mode16),
    .out_valid(out_valid16), .out_ready(out_ready16), .out_data(out_data16), .out_lost(out_lost16)
  );

  int unsigned total  = 0;
  int unsigned passed = 0;

  typedef struct {
    logic [31:0] d;
    logic        l;
  } item_t;
  item_t sb[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: value-level arithmetic on signed integers, then truncation to the output width
  function automatic void ref_ext(input int unsigned inw, input int unsigned outw,
                                  input int unsigned sh, input longint unsigned d,
                                  input logic [1:0] m, output logic [63:0] ext,
                                  output logic lost);
    longint v, p, lim;
    longint unsigned mask;
    mask = (64'd1 << outw) - 64'd1;
    v    = longint'(d);
    if (((d >> (inw - 1)) & 64'd1) == 64'd1) v = v - (longint'(1) << inw);
    lim  = longint'(1) << (outw - 1);
    lost = 1'b0;
    case (m)
      MODE_SEXT:  ext = v & mask;
      MODE_ZEXT:  ext = d & mask;
      MODE_UPPER: ext = (d << (outw - inw)) & mask;
      default: begin
        p    = v * (longint'(1) << sh);
        ext  = p & mask;
        lost = (p >= lim) || (p < -lim);
      end
    endcase
  endfunction

  task automatic send_check(input string tag, input logic [1:0] m, input logic [15:0] d,
                            input logic [31:0] exp_d, input logic exp_l);
    @(negedge clk);
    in_valid = 1'b1; in_mode = m; in_data = d; out_ready = 1'b1;
    check({tag, "_in_ready"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_data"}, out_data, exp_d);
    check({tag, "_lost"}, out_lost, exp_l);
    @(negedge clk);
    check({tag, "_valid_drop"}, out_valid, 0);
  endtask

  task automatic send16(input string tag, input logic [15:0] d,
                        input logic [15:0] exp_d, input logic exp_l);
    @(negedge clk);
    in_valid16 = 1'b1; in_mode16 = MODE_BRANCH; in_data16 = d; out_ready16 = 1'b1;
    @(negedge clk);
    in_valid16 = 1'b0;
    check({tag, "_valid"}, out_valid16, 1);
    check({tag, "_data"}, out_data16, exp_d);
    check({tag, "_lost"}, out_lost16, exp_l);
  endtask

  initial begin
    int unsigned sent, got, cyc;
    bit          hold;
    logic [63:0] e;
    logic        l;
    item_t       it;

    reset_n = 1'b0;
    in_valid = 1'b0; in_data = '0; in_mode = MODE_SEXT; out_ready = 1'b0;
    in_valid16 = 1'b0; in_data16 = '0; in_mode16 = MODE_SEXT; out_ready16 = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_data", out_data, 0);
    check("rst_out_lost", out_lost, 0);
    reset_n = 1'b1;

    // Single-item mode checks at full throughput
    send_check("sext_8000",   MODE_SEXT,   16'h8000, 32'hFFFF8000, 1'b0);
    send_check("zext_8000",   MODE_ZEXT,   16'h8000, 32'h00008000, 1'b0);
    send_check("upper_1234",  MODE_UPPER,  16'h1234, 32'h12340000, 1'b0);
    send_check("branch_ffff", MODE_BRANCH, 16'hFFFF, 32'hFFFFFFFC, 1'b0);
    send_check("branch_7fff", MODE_BRANCH, 16'h7FFF, 32'h0001FFFC, 1'b0);

    // OUT_WIDTH == IN_WIDTH branch overflow boundary
    send16("b16_4000", 16'h4000, 16'h0000, 1'b1);
    send16("b16_e000", 16'hE000, 16'h8000, 1'b0);
    send16("b16_dfff", 16'hDFFF, 16'h7FFC, 1'b1);

    // Backpressure: fill out reg + skid, hold third item, then drain in order
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_mode = MODE_SEXT; in_data = 16'd1;
    @(negedge clk);
    check("bp_ready_after1", in_ready, 1);
    check("bp_data1_head", out_data, 32'd1);
    in_data = 16'd2;
    @(negedge clk);
    check("bp_ready_full", in_ready, 0);
    in_data = 16'd3;
    @(negedge clk);
    check("bp_ready_held", in_ready, 0);
    check("bp_hold_data1", out_data, 32'd1);
    check("bp_hold_valid", out_valid, 1);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_data2", out_data, 32'd2);
    check("bp_ready_reopen", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_data3", out_data, 32'd3);
    check("bp_valid3", out_valid, 1);
    @(negedge clk);
    check("bp_empty", out_valid, 0);

    // Randomized traffic against the queue model
    sent = 0; got = 0; cyc = 0; hold = 1'b0;
    while (got < 10000 && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      check("rnd_in_ready", in_ready, (sb.size() < 2));
      check("rnd_out_valid", out_valid, (sb.size() != 0));
      if (!hold) begin
        in_valid = (sent < 10000) && ($urandom_range(0, 3) != 0);
        in_mode  = 2'($urandom_range(0, 3));
        case ($urandom_range(0, 7))
          0: in_data = 16'h0000;
          1: in_data = 16'hFFFF;
          2: in_data = 16'h8000;
          3: in_data = 16'h7FFF;
          4: in_data = 16'h2000 ^ 16'($urandom_range(0, 3));
          5: in_data = 16'hDFFF ^ 16'($urandom_range(0, 3));
          default: in_data = 16'($urandom);
        endcase
      end
      case ((cyc / 700) % 3)
        0: out_ready = ($urandom_range(0, 3) != 0);
        1: out_ready = ($urandom_range(0, 3) == 0);
        default: out_ready = $urandom_range(0, 1) != 0;
      endcase
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("rnd_unexpected_output", 1, 0);
        end else begin
          it = sb.pop_front();
          check("rnd_data", out_data, it.d);
          check("rnd_lost", out_lost, it.l);
        end
        got++;
      end
      if (in_valid && in_ready) begin
        ref_ext(16, 32, 2, 64'(in_data), in_mode, e, l);
        it.d = e[31:0];
        it.l = l;
        sb.push_back(it);
        sent++;
        hold = 1'b0;
      end else begin
        hold = in_valid;
      end
    end
    check("rnd_delivered", got, 10000);
    check("rnd_leftover", sb.size(), 0);

    // Asynchronous reset while both entries are occupied
    @(negedge clk);
    in_valid = 1'b1; in_mode = MODE_ZEXT; in_data = 16'hAAAA; out_ready = 1'b0;
    @(negedge clk);
    in_data = 16'h5555;
    @(negedge clk);
    in_valid = 1'b0;
    check("arst_pre_full", in_ready, 0);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_out_data", out_data, 0);
    check("arst_out_lost", out_lost, 0);
    @(negedge clk);
    reset_n = 1'b1;
    in_valid = 1'b1; in_mode = MODE_SEXT; in_data = 16'h0005; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("arst_first_valid", out_valid, 1);
    check("arst_first_data", out_data, 32'd5);
    @(negedge clk);
    check("arst_no_stale", out_valid, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_imm_extend_pipe
